// File: rtl/pipe_wb_pkg.sv
// Shared definitions for the MIPS write-back stage: datapath width default,
// register index width, register count and the hardwired zero register.
package pipe_wb_pkg;

  localparam int DATA_L_DEF = 32;
  localparam int REG_IDX_L  = 5;
  localparam int REG_CNT    = 32;

  localparam logic [REG_IDX_L-1:0] REG_ZERO = '0;

  // True when an instruction really changes architectural state in the file.
  function automatic logic writes_reg(input logic e, input logic [REG_IDX_L-1:0] idx);
    return e && (idx != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipe_wb_regfile.sv
// General-purpose register file: one synchronous write port, two
// combinational read ports, r0 reads as zero and ignores writes.
module wb_regfile
  import pipe_wb_pkg::*;
#(
  parameter int DATA_L = DATA_L_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_IDX_L-1:0] wr_idx,
  input  logic [DATA_L-1:0]    wr_data,
  input  logic [REG_IDX_L-1:0] ra_idx,
  input  logic [REG_IDX_L-1:0] rb_idx,
  output logic [DATA_L-1:0]    ra_data,
  output logic [DATA_L-1:0]    rb_data
);

  logic [DATA_L-1:0] rf [REG_CNT];

  // NOTE: the array is cleared on reset because all registers must read zero
  // afterwards; this forces flops instead of a RAM macro, which is intended here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) rf[i] <= '0;
    end else if (writes_reg(we, wr_idx)) begin
      rf[wr_idx] <= wr_data;
    end
  end

  assign ra_data = (ra_idx == REG_ZERO) ? '0 : rf[ra_idx];
  assign rb_data = (rb_idx == REG_ZERO) ? '0 : rf[rb_idx];

endmodule

// File: rtl/pipe_wb.sv
// Write-back stage: one-entry pending register, commit into wb_regfile,
// EX forwarding and retire counter. Optional read bypass: WB_BYPASS_EN.
module pipe_wb
  import pipe_wb_pkg::*;
#(
  parameter int DATA_L = DATA_L_DEF,
  parameter int CNT_L  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ma_valid,
  output logic                 ma_ready,
  input  logic                 ma_wb_e,
  input  logic [REG_IDX_L-1:0] ma_wb_idx,
  input  logic [DATA_L-1:0]    ma_wb_data,
  input  logic                 wb_hold,
  input  logic [REG_IDX_L-1:0] id_ra_idx,
  input  logic [REG_IDX_L-1:0] id_rb_idx,
  output logic [DATA_L-1:0]    id_ra_data,
  output logic [DATA_L-1:0]    id_rb_data,
  output logic                 fwd_valid,
  output logic [REG_IDX_L-1:0] fwd_idx,
  output logic [DATA_L-1:0]    fwd_data,
  output logic [CNT_L-1:0]     retire_cnt
);

  logic                 pend_v;
  logic                 pend_e;
  logic [REG_IDX_L-1:0] pend_idx;
  logic [DATA_L-1:0]    pend_data;

  logic              accept;
  logic              commit;
  logic [DATA_L-1:0] rf_ra_data;
  logic [DATA_L-1:0] rf_rb_data;

  // Hold only back-pressures MA when there is something stuck in the slot.
  assign ma_ready = !pend_v || !wb_hold;
  assign accept   = ma_valid && ma_ready;
  assign commit   = pend_v && !wb_hold;

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; accept and commit in one cycle then replace the slot cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v     <= 1'b0;
      pend_e     <= 1'b0;
      pend_idx   <= REG_ZERO;
      pend_data  <= '0;
      retire_cnt <= '0;
    end else begin
      if (accept) begin
        pend_v    <= 1'b1;
        pend_e    <= ma_wb_e;
        pend_idx  <= ma_wb_idx;
        pend_data <= ma_wb_data;
      end else if (commit) begin
        pend_v <= 1'b0;
      end
      if (commit) retire_cnt <= retire_cnt + CNT_L'(1);
    end
  end

  wb_regfile #(.DATA_L(DATA_L)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (commit && pend_e),
    .wr_idx  (pend_idx),
    .wr_data (pend_data),
    .ra_idx  (id_ra_idx),
    .rb_idx  (id_rb_idx),
    .ra_data (rf_ra_data),
    .rb_data (rf_rb_data)
  );

  assign fwd_valid = pend_v && writes_reg(pend_e, pend_idx);
  assign fwd_idx   = pend_idx;
  assign fwd_data  = pend_data;

`ifdef WB_BYPASS_EN
  // fwd_valid already excludes r0, so the zero register stays hardwired.
  assign id_ra_data = (fwd_valid && pend_idx == id_ra_idx) ? pend_data : rf_ra_data;
  assign id_rb_data = (fwd_valid && pend_idx == id_rb_idx) ? pend_data : rf_rb_data;
`else
  assign id_ra_data = rf_ra_data;
  assign id_rb_data = rf_rb_data;
`endif

endmodule

// File: tb/tb_pipe_wb.sv
// Self-checking bench for pipe_wb: directed test-plan scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_pipe_wb;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ma_valid = 1'b0;
  logic        ma_wb_e = 1'b0;
  logic [4:0]  ma_wb_idx = '0;
  logic [31:0] ma_wb_data = '0;
  logic        wb_hold = 1'b0;
  logic [4:0]  id_ra_idx = '0;
  logic [4:0]  id_rb_idx = '0;

  logic        ma_ready, fwd_valid;
  logic [4:0]  fwd_idx;
  logic [31:0] id_ra_data, id_rb_data, fwd_data, retire_cnt;

  logic        ma_ready4, fwd_valid4;
  logic [4:0]  fwd_idx4;
  logic [31:0] id_ra_data4, id_rb_data4, fwd_data4;
  logic [3:0]  retire_cnt4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_wb #(.DATA_L(32), .CNT_L(32)) dut (
    .clk(clk), .rst(rst), .ma_valid(ma_valid), .ma_ready(ma_ready),
    .ma_wb_e(ma_wb_e), .ma_wb_idx(ma_wb_idx), .ma_wb_data(ma_wb_data),
    .wb_hold(wb_hold), .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx),
    .id_ra_data(id_ra_data), .id_rb_data(id_rb_data),
    .fwd_valid(fwd_valid), .fwd_idx(fwd_idx), .fwd_data(fwd_data),
    .retire_cnt(retire_cnt)
  );

  // Narrow-counter instance shares the stimulus to exercise counter wrap.
  pipe_wb #(.DATA_L(32), .CNT_L(4)) dut4 (
    .clk(clk), .rst(rst), .ma_valid(ma_valid), .ma_ready(ma_ready4),
    .ma_wb_e(ma_wb_e), .ma_wb_idx(ma_wb_idx), .ma_wb_data(ma_wb_data),
    .wb_hold(wb_hold), .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx),
    .id_ra_data(id_ra_data4), .id_rb_data(id_rb_data4),
    .fwd_valid(fwd_valid4), .fwd_idx(fwd_idx4), .fwd_data(fwd_data4),
    .retire_cnt(retire_cnt4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          e;
    bit [4:0]    idx;
    bit [31:0]   data;
  } ent_t;

  ent_t        pend[$];
  ent_t        last;
  bit [31:0]   m_rf [32];
  int unsigned m_cnt;
  bit          m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      last  = '{e: 1'b0, idx: 5'd0, data: 32'd0};
      foreach (m_rf[i]) m_rf[i] = 32'd0;
      m_cnt  = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      bit room;
      room = (pend.size() == 0) || !wb_hold;
      if (pend.size() != 0 && !wb_hold) begin
        ent_t c;
        c = pend.pop_front();
        if (c.e && c.idx != 0) m_rf[c.idx] = c.data;
        m_cnt++;
      end
      if (ma_valid && room) begin
        last = '{e: ma_wb_e, idx: ma_wb_idx, data: ma_wb_data};
        pend.push_back(last);
      end
    end
  end

  function automatic bit [31:0] exp_read(input bit [4:0] idx);
    if (idx == 0) return 32'd0;
    if (BYP && pend.size() != 0 && last.e && last.idx == idx) return last.data;
    return m_rf[idx];
  endfunction

  // Compare process: every negedge once the model has seen reset.
  always @(negedge clk) begin
    if (m_live) begin
      bit fv;
      fv = (pend.size() != 0) && last.e && (last.idx != 0);
      check("ma_ready",    ma_ready,    (pend.size() == 0) || !wb_hold);
      check("ma_ready4",   ma_ready4,   (pend.size() == 0) || !wb_hold);
      check("fwd_valid",   fwd_valid,   fv);
      check("fwd_idx",     fwd_idx,     last.idx);
      check("fwd_data",    fwd_data,    last.data);
      check("id_ra_data",  id_ra_data,  exp_read(id_ra_idx));
      check("id_rb_data",  id_rb_data,  exp_read(id_rb_idx));
      check("retire_cnt",  retire_cnt,  m_cnt);
      check("retire_cnt4", retire_cnt4, m_cnt % 16);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit e, input bit [4:0] idx, input bit [31:0] data);
    ma_valid = v; ma_wb_e = e; ma_wb_idx = idx; ma_wb_data = data;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    check("rst_ma_ready", ma_ready, 1'b1);
    check("rst_retire", retire_cnt, 0);
    check("rst_fwd_valid", fwd_valid, 1'b0);
    check("rst_fwd_data", fwd_data, 0);

    // Back-to-back writes
    drive(1, 1, 5'd3, 32'h11); cyc();
    drive(1, 1, 5'd4, 32'h22); cyc();
    drive(1, 1, 5'd3, 32'h33); cyc();
    drive(0, 0, 5'd0, 32'h0);  cyc();
    id_ra_idx = 5'd3; id_rb_idx = 5'd4; #1;
    check("b2b_r3", id_ra_data, 32'h33);
    check("b2b_r4", id_rb_data, 32'h22);
    check("b2b_cnt", retire_cnt, 3);

    // r0 write is counted but dropped
    drive(1, 1, 5'd0, 32'hDEADBEEF); cyc();
    drive(0, 0, 5'd0, 32'h0);
    check("r0_fwd_valid", fwd_valid, 1'b0);
    id_ra_idx = 5'd0; #1;
    check("r0_read_pend", id_ra_data, 0);
    cyc();
    check("r0_cnt", retire_cnt, 4);
    check("r0_read", id_ra_data, 0);

    // Hold with a pending r7 write and MA pushing r8
    drive(1, 1, 5'd7, 32'h55); cyc();
    drive(1, 1, 5'd8, 32'h66);
    wb_hold = 1'b1; id_ra_idx = 5'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_ready", ma_ready, 1'b0);
      check("hold_r7", id_ra_data, BYP ? 32'h55 : 32'h0);
      check("hold_cnt", retire_cnt, 4);
      cyc();
    end
    wb_hold = 1'b0; #1;
    check("release_ready", ma_ready, 1'b1);
    cyc();
    drive(0, 0, 5'd0, 32'h0); #1;
    check("release_r7", id_ra_data, 32'h55);
    check("release_fwd_idx", fwd_idx, 5'd8);
    check("release_cnt", retire_cnt, 5);
    cyc();

    // Bypass visibility
    drive(1, 1, 5'd9, 32'hABCD); cyc();
    drive(0, 0, 5'd0, 32'h0);
    id_ra_idx = 5'd9; #1;
    check("byp_early", id_ra_data, BYP ? 32'hABCD : 32'h0);
    cyc();
    check("byp_late", id_ra_data, 32'hABCD);

    // Counter wrap on the 4-bit instance: 17 commits
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 5'(i), 32'(i)); cyc();
    end
    drive(0, 0, 5'd0, 32'h0); cyc();
    check("wrap_cnt4", retire_cnt4, 4'd1);
    check("wrap_cnt", retire_cnt, 17);

    // Reset mid-stream discards the pending r5 write
    drive(1, 1, 5'd5, 32'h77); cyc();
    check("mid_pend", fwd_valid, 1'b1);
    drive(0, 0, 5'd0, 32'h0); rst = 1'b1; cyc();
    rst = 1'b0; id_ra_idx = 5'd5; #1;
    check("mid_ready", ma_ready, 1'b1);
    check("mid_cnt", retire_cnt, 0);
    cyc();
    check("mid_r5", id_ra_data, 0);
    check("mid_cnt2", retire_cnt, 0);

    // Randomized traffic, checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      wb_hold   = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
            5'($urandom_range(0, 7)), $urandom);
      id_ra_idx = 5'($urandom_range(0, 7));
      id_rb_idx = 5'($urandom_range(0, 31));
      cyc();
    end
    rst = 1'b0; wb_hold = 1'b0; drive(0, 0, 5'd0, 32'h0);
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
